// File: rtl/tt_um_bmsce_t2_pkg.sv
// Shared constants and types for the Choreo8 light-choreography sequencer.
package tt_um_bmsce_t2_pkg;

    localparam int          STEPS         = 8;
    localparam int          STEP_W        = $clog2(STEPS);
    localparam int          PRESCALE_BITS = 12;
    localparam logic [7:0]  UIO_OE_VAL    = 8'hC0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit layout of uio_in, MSB first.
    typedef struct packed {
        logic              spare;
        logic              loop;
        logic              run;
        logic              sel;
        logic [STEP_W-1:0] addr;
        logic              wr;
    } ctrl_t;

endpackage

// File: rtl/choreo8_step_mem.sv
// Eight-entry pattern and duration register files with a shared write port
// and a combinational read port indexed by the current step.
module choreo8_step_mem
    import tt_um_bmsce_t2_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic              sel,
    input  logic [STEP_W-1:0] addr,
    input  logic [7:0]        wdata,
    input  logic [STEP_W-1:0] rd_idx,
    output logic [7:0]        pat_o,
    output logic [7:0]        dur_o
);

    logic [STEPS-1:0][7:0] pat_q, pat_d;
    logic [STEPS-1:0][7:0] dur_q, dur_d;

    always_comb begin
        pat_d = pat_q;
        dur_d = dur_q;
        if (wr) begin
            if (sel) dur_d[addr] = wdata;
            else     pat_d[addr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= '0;
            dur_q <= '0;
        end else begin
            pat_q <= pat_d;
            dur_q <= dur_d;
        end
    end

    // Reads see the pre-write contents, so a same-cycle write never affects the compare.
    assign pat_o = pat_q[rd_idx];
    assign dur_o = dur_q[rd_idx];

endmodule

// File: rtl/tt_um_bmsce_t2.sv
// Choreo8 top: run-edge FSM, step/tick counters and output muxing.
// Define CHOREO8_PRESCALE_EN to slow ticks to one per 4096 clocks.
module tt_um_bmsce_t2
    import tt_um_bmsce_t2_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    ctrl_t ctrl;
    assign ctrl = ctrl_t'(uio_in);

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, ctrl.spare};

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              run_d_q, run_d_d;
    logic              tick;
    logic [7:0]        cur_pat, cur_dur;

    choreo8_step_mem u_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr     (ctrl.wr),
        .sel    (ctrl.sel),
        .addr   (ctrl.addr),
        .wdata  (ui_in),
        .rd_idx (step_q),
        .pat_o  (cur_pat),
        .dur_o  (cur_dur)
    );

`ifdef CHOREO8_PRESCALE_EN
    logic [PRESCALE_BITS-1:0] presc_q, presc_d;

    // Restart the prescaler on PLAY entry so step 0 gets a full tick period.
    always_comb begin
        presc_d = presc_q + 1'b1;
        if (state_d == ST_PLAY && state_q != ST_PLAY) presc_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) presc_q <= '0;
        else        presc_q <= presc_d;
    end

    assign tick = (presc_q == '1);
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        run_d_d = ctrl.run;
        if (!ctrl.run) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!run_d_q) begin
                        state_d = ST_PLAY;
                        step_d  = '0;
                        cnt_d   = '0;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        if (cnt_q == cur_dur) begin
                            cnt_d = '0;
                            if (step_q == STEP_W'(STEPS - 1)) begin
                                if (ctrl.loop) step_d  = '0;
                                else           state_d = ST_DONE;
                            end else begin
                                step_d = step_q + 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
            run_d_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            run_d_q <= run_d_d;
        end
    end

    assign uo_out  = (state_q == ST_IDLE) ? 8'h00 : cur_pat;
    assign uio_out = {state_q == ST_PLAY, state_q == ST_DONE, 6'b0};
    assign uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_bmsce_t2.sv
// Directed bench for Choreo8: reset, one-shot, durations, loop, abort,
// write-during-play, mid-play reset and the 256-tick duration boundary.
module tb_tt_um_bmsce_t2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    logic run  = 1'b0;
    logic loop = 1'b0;
    int   total = 0;
    int   bad   = 0;

    tt_um_bmsce_t2 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic sel, input logic [2:0] addr);
        uio_in = {1'b0, loop, run, sel, addr, wr};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One write cycle; leaves WR low afterwards.
    task automatic wr_mem(input logic sel, input logic [2:0] addr, input logic [7:0] d);
        ui_in = d;
        drive(1'b1, sel, addr);
        tick();
        drive(1'b0, 1'b0, 3'd0);
    endtask

    task automatic set_run(input logic r);
        run = r;
        drive(1'b0, 1'b0, 3'd0);
    endtask

    initial begin
        logic [7:0] exp_pat;

        // Reset state
        #1;
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_uio", uio_out, 8'h00);
        chk("rst_oe", uio_oe, 8'hC0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_uo", uo_out, 8'h00);
        chk("idle_uio", uio_out, 8'h00);

        // One-shot, all durations 0
        for (int i = 0; i < 8; i++) wr_mem(1'b0, 3'(i), 8'(1 << i));
        set_run(1'b1);
        tick();
        chk("os_step0", uo_out, 8'h01);
        chk("os_play", uio_out, 8'h80);
        for (int k = 1; k < 8; k++) begin
            tick();
            exp_pat = 8'(1 << k);
            chk("os_step", uo_out, exp_pat);
        end
        chk("os_play7", uio_out, 8'h80);
        tick();
        chk("os_done", uio_out, 8'h40);
        chk("os_hold", uo_out, 8'h80);
        tick();
        chk("os_done2", uio_out, 8'h40);

        // Durations: dur[2]=3
        set_run(1'b0);
        tick();
        chk("fall_uo", uo_out, 8'h00);
        chk("fall_uio", uio_out, 8'h00);
        wr_mem(1'b1, 3'd2, 8'd3);
        set_run(1'b1);
        tick();
        chk("du_s0", uo_out, 8'h01);
        tick();
        chk("du_s1", uo_out, 8'h02);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("du_s2", uo_out, 8'h04);
        end
        tick();
        chk("du_s3", uo_out, 8'h08);
        for (int i = 0; i < 4; i++) tick();
        chk("du_s7", uo_out, 8'h80);
        chk("du_play", uio_out, 8'h80);
        tick();
        chk("du_done", uio_out, 8'h40);
        set_run(1'b0);
        tick();
        wr_mem(1'b1, 3'd2, 8'd0);

        // Loop
        loop = 1'b1;
        set_run(1'b1);
        tick();
        chk("lp_s0", uo_out, 8'h01);
        for (int i = 0; i < 7; i++) tick();
        chk("lp_s7", uo_out, 8'h80);
        tick();
        chk("lp_wrap", uo_out, 8'h01);
        chk("lp_play", uio_out, 8'h80);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("lp_nodone", uio_out, 8'h80);
        end
        chk("lp_s4", uo_out, 8'h10);
        set_run(1'b0);
        loop = 1'b0;
        tick();

        // Abort mid-step 3, then restart
        set_run(1'b1);
        for (int i = 0; i < 4; i++) tick();
        chk("ab_s3", uo_out, 8'h08);
        set_run(1'b0);
        tick();
        chk("ab_uo", uo_out, 8'h00);
        chk("ab_uio", uio_out, 8'h00);
        set_run(1'b1);
        tick();
        chk("ab_restart", uo_out, 8'h01);

        // Write during play, pat[5] on step 2
        tick();
        tick();
        chk("wp_s2", uo_out, 8'h04);
        wr_mem(1'b0, 3'd5, 8'hAA);
        chk("wp_s3", uo_out, 8'h08);
        tick();
        tick();
        chk("wp_s5", uo_out, 8'hAA);

        // Mid-play reset with RUN held high
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_uo", uo_out, 8'h00);
        chk("mr_uio", uio_out, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mr_play", uio_out, 8'h80);
        chk("mr_s0", uo_out, 8'h00);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("mr_cleared", uo_out, 8'h00);
        end
        tick();
        chk("mr_done", uio_out, 8'h40);

        // dur=255 lasts 256 ticks
        set_run(1'b0);
        tick();
        wr_mem(1'b0, 3'd0, 8'h5A);
        wr_mem(1'b0, 3'd1, 8'hC3);
        wr_mem(1'b1, 3'd0, 8'hFF);
        set_run(1'b1);
        tick();
        chk("d255_first", uo_out, 8'h5A);
        for (int i = 0; i < 255; i++) tick();
        chk("d255_last", uo_out, 8'h5A);
        tick();
        chk("d255_next", uo_out, 8'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
